// File: rtl/demux8_stream.sv
// 1-to-8 registered stream demultiplexer with a one-entry holding register.
// Optional per-channel drain counters are built when DEMUX8_STATS_EN is defined.
module demux8_stream #(
   parameter int DATA_WIDTH = 64
`ifdef DEMUX8_STATS_EN
   , parameter int CNT_WIDTH = 16
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic [2:0]              in_sel,
   output logic [7:0]              out_valid,
   input  logic [7:0]              out_ready,
   output logic [DATA_WIDTH-1:0]   out_data
`ifdef DEMUX8_STATS_EN
   , output logic [8*CNT_WIDTH-1:0] stat_cnt
   , input  logic                   stat_clr
`endif
);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [2:0]            r_hold_sel;
   logic [DATA_WIDTH-1:0] r_hold_data;
   logic                  w_drain;
   logic                  w_accept;

   // Only the addressed channel's ready matters; others are ignored.
   assign w_drain  = (r_state == S_FULL) && out_ready[r_hold_sel];
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
         S_FULL:  if (w_drain && !w_accept) w_state_nxt = S_EMPTY;
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 8'h00;
      case (r_state)
         S_EMPTY: in_ready = 1'b1;
         S_FULL: begin
            in_ready  = w_drain;
            out_valid = 8'b1 << r_hold_sel;
         end
         default: ;
      endcase
   end

   // Payload is only loaded on accept, so it keeps its last value after a drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_sel  <= 3'd0;
         r_hold_data <= '0;
      end else if (w_accept) begin
         r_hold_sel  <= in_sel;
         r_hold_data <= in_data;
      end
   end

   assign out_data = r_hold_data;

`ifdef DEMUX8_STATS_EN
   logic [CNT_WIDTH-1:0] r_cnt [8];

   for (genvar k = 0; k < 8; k++) begin : g_cnt
      // Clear wins over a same-cycle drain.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cnt[k] <= '0;
         end else if (stat_clr) begin
            r_cnt[k] <= '0;
         end else if (w_drain && (r_hold_sel == 3'(k))) begin
            r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
         end
      end
      assign stat_cnt[k*CNT_WIDTH +: CNT_WIDTH] = r_cnt[k];
   end
`endif

endmodule
